// File: rtl/iddr_word_gearbox_pkg.sv
// Shared definitions for the IDDR word gearbox: training state encodings and
// the slip-offset counter width.
package iddr_word_gearbox_pkg;

    localparam int SLIP_W = 4;

    typedef enum logic [2:0] {
        ST_PASS   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_VERIFY = 3'd3,
        ST_FAIL   = 3'd4
    } train_state_t;

endpackage

// File: rtl/iddr_word_gearbox_train.sv
// Alignment training FSM: hunts for TRAIN_PAT by slipping one bit per try,
// then demands LOCK_COUNT consecutive matches before declaring lock.
module iddr_gear_train
    import iddr_word_gearbox_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_word_done,
    input  logic i_word_match,
    input  logic i_train_en,
    output logic o_slip,
    output logic o_locked,
    output logic o_train_err,
    output logic o_pass_mode
);

    localparam logic [SLIP_W-1:0] TRIES_LAST = SLIP_W'(WIDTH - 1);
    localparam logic [3:0]        MATCH_LAST = 4'(LOCK_COUNT - 1);

    train_state_t      r_state, w_state_nxt;
    logic              r_train_q;
    logic [SLIP_W-1:0] r_tries, w_tries_nxt;
    logic [3:0]        r_match_cnt, w_match_nxt;
    logic              r_locked, w_locked_nxt;
    logic              r_err, w_err_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_PASS;
            r_train_q   <= 1'b0;
            r_tries     <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_train_q   <= i_train_en;
            r_tries     <= w_tries_nxt;
            r_match_cnt <= w_match_nxt;
            r_locked    <= w_locked_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tries_nxt  = r_tries;
        w_match_nxt  = r_match_cnt;
        w_locked_nxt = r_locked;
        w_err_nxt    = r_err;
        o_slip       = 1'b0;
        case (r_state)
            ST_PASS: begin
                if (i_train_en && !r_train_q) begin
                    w_locked_nxt = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_tries_nxt  = '0;
                    w_match_nxt  = '0;
                    w_state_nxt  = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (!i_train_en) begin
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = ST_PASS;
                end else if (i_word_done) begin
                    if (i_word_match) begin
                        w_match_nxt = 4'd1;
                        if (LOCK_COUNT == 1) begin
                            w_locked_nxt = 1'b1;
                            w_state_nxt  = ST_PASS;
                        end else begin
                            w_state_nxt = ST_VERIFY;
                        end
                    end else if (r_tries == TRIES_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FAIL;
                    end else begin
                        o_slip      = 1'b1;
                        w_tries_nxt = r_tries + 1'b1;
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // The word straddling the slip is meaningless; skip it.
                if (!i_train_en) begin
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = ST_PASS;
                end else if (i_word_done) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_VERIFY: begin
                if (!i_train_en) begin
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = ST_PASS;
                end else if (i_word_done) begin
                    if (i_word_match) begin
                        w_match_nxt = r_match_cnt + 1'b1;
                        if (r_match_cnt == MATCH_LAST) begin
                            w_locked_nxt = 1'b1;
                            w_state_nxt  = ST_PASS;
                        end
                    end else begin
                        w_match_nxt = '0;
                        w_state_nxt = ST_HUNT;
                    end
                end
            end
            ST_FAIL: begin
                if (!i_train_en) w_state_nxt = ST_PASS;
            end
            default: w_state_nxt = ST_PASS;
        endcase
    end

    assign o_locked    = r_locked;
    assign o_train_err = r_err;
    assign o_pass_mode = (r_state == ST_PASS);

endmodule

// File: rtl/iddr_word_gearbox.sv
// Assembles IDDR QA/QB pairs into WIDTH-bit words with a selectable bit
// offset; the training sub-module picks the offset that yields TRAIN_PAT.
module iddr_word_gearbox
    import iddr_word_gearbox_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TRAIN_PAT  = WIDTH'(8'hA5),
    parameter int               LOCK_COUNT = 4
) (
    input  logic              SCLK,
    input  logic              RSTB,
    input  logic              QA,
    input  logic              QB,
    input  logic              EN,
    input  logic              TRAIN_EN,
    output logic [WIDTH-1:0]  DOUT,
    output logic              DVALID,
    output logic              LOCKED,
    output logic              TRAIN_ERR,
    output logic [SLIP_W-1:0] SLIP_CNT
);

    localparam int                PH_W      = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(WIDTH / 2 - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_hist;
    logic [PH_W-1:0]    r_phase;
    logic [SLIP_W-1:0]  r_slip_cnt;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dvalid;

    logic [2*WIDTH-1:0] w_hist_nxt;
    logic [WIDTH-1:0]   w_word;
    logic               w_word_done;
    logic               w_slip;
    logic               w_pass_mode;

    // Newest pair enters at the bottom, so older bits sit at higher indices.
    assign w_hist_nxt  = {r_hist[2*WIDTH-3:0], QA, QB};
    assign w_word      = w_hist_nxt[r_slip_cnt +: WIDTH];
    assign w_word_done = EN && (r_phase == PH_LAST);

    always_ff @(posedge SCLK) begin
        if (RSTB) begin
            r_hist     <= '0;
            r_phase    <= '0;
            r_slip_cnt <= '0;
            r_dout     <= '0;
            r_dvalid   <= 1'b0;
        end else begin
            if (EN) begin
                r_hist  <= w_hist_nxt;
                r_phase <= w_word_done ? '0 : r_phase + 1'b1;
            end
            if (w_slip) r_slip_cnt <= (r_slip_cnt == SLIP_LAST) ? '0 : r_slip_cnt + 1'b1;
            r_dvalid <= w_word_done && w_pass_mode;
            if (w_word_done && w_pass_mode) r_dout <= w_word;
        end
    end

    iddr_gear_train #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_train (
        .i_clk        (SCLK),
        .i_rst        (RSTB),
        .i_word_done  (w_word_done),
        .i_word_match (w_word == TRAIN_PAT),
        .i_train_en   (TRAIN_EN),
        .o_slip       (w_slip),
        .o_locked     (LOCKED),
        .o_train_err  (TRAIN_ERR),
        .o_pass_mode  (w_pass_mode)
    );

    assign DOUT     = r_dout;
    assign DVALID   = r_dvalid;
    assign SLIP_CNT = r_slip_cnt;

endmodule

// File: tb/tb_iddr_word_gearbox.sv
// Directed bench for iddr_word_gearbox (WIDTH=8, TRAIN_PAT=A5, LOCK_COUNT=4).
// Inputs change 1ns after each SCLK rising edge; outputs are sampled there too.
module tb_iddr_word_gearbox;

    localparam int W = 8;

    logic         SCLK = 1'b0;
    logic         RSTB = 1'b1;
    logic         QA = 1'b0, QB = 1'b0, EN = 1'b0, TRAIN_EN = 1'b0;
    logic [W-1:0] DOUT;
    logic         DVALID, LOCKED, TRAIN_ERR;
    logic [3:0]   SLIP_CNT;

    int errors = 0;
    int checks = 0;
    bit bq[$];

    always #5 SCLK = ~SCLK;

    iddr_word_gearbox #(
        .WIDTH      (W),
        .TRAIN_PAT  (8'hA5),
        .LOCK_COUNT (4)
    ) dut (
        .SCLK      (SCLK),
        .RSTB      (RSTB),
        .QA        (QA),
        .QB        (QB),
        .EN        (EN),
        .TRAIN_EN  (TRAIN_EN),
        .DOUT      (DOUT),
        .DVALID    (DVALID),
        .LOCKED    (LOCKED),
        .TRAIN_ERR (TRAIN_ERR),
        .SLIP_CNT  (SLIP_CNT)
    );

    task automatic tick(input logic qa, input logic qb, input logic en);
        QA = qa; QB = qb; EN = en;
        @(posedge SCLK);
        #1;
    endtask

    task automatic tick_q();
        bit a, b;
        a = bq.pop_front();
        b = bq.pop_front();
        tick(a, b, 1'b1);
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bq.push_back(v[i]);
    endtask

    task automatic do_reset();
        RSTB = 1'b1; TRAIN_EN = 1'b0; bq.delete();
        repeat (2) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        RSTB = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        push_byte(8'hA5);
        repeat (4) tick_q();
        checks++; if (DOUT !== 8'hA5) begin errors++; $display("FAIL reset_pre_dout got=%h exp=a5", DOUT); end
        do_reset();
        checks++; if (DOUT !== 8'h00)    begin errors++; $display("FAIL reset_dout got=%h exp=00", DOUT); end
        checks++; if (DVALID !== 1'b0)   begin errors++; $display("FAIL reset_dvalid got=%b exp=0", DVALID); end
        checks++; if (LOCKED !== 1'b0)   begin errors++; $display("FAIL reset_locked got=%b exp=0", LOCKED); end
        checks++; if (TRAIN_ERR !== 1'b0) begin errors++; $display("FAIL reset_train_err got=%b exp=0", TRAIN_ERR); end
        checks++; if (SLIP_CNT !== 4'd0) begin errors++; $display("FAIL reset_slip got=%0d exp=0", SLIP_CNT); end
    endtask

    // Pairs MSB-first; 1E and C8 are not bit-palindromes so they catch order bugs.
    task automatic test_steady();
        logic [7:0] pats [5] = '{8'hA5, 8'hA5, 8'hA5, 8'h1E, 8'hC8};
        do_reset();
        for (int k = 0; k < 5; k++) push_byte(pats[k]);
        for (int i = 0; i < 20; i++) begin
            tick_q();
            checks++; if (DVALID !== (i % 4 == 3)) begin errors++; $display("FAIL steady_dvalid cyc=%0d got=%b exp=%b", i, DVALID, (i % 4 == 3)); end
            if (i % 4 == 3) begin
                checks++; if (DOUT !== pats[i/4]) begin errors++; $display("FAIL steady_dout word=%0d got=%h exp=%h", i/4, DOUT, pats[i/4]); end
            end
        end
    endtask

    task automatic test_en_gaps();
        int         n_en = 0;
        logic       exp_v;
        logic [7:0] exp_d = 8'h00;
        do_reset();
        push_byte(8'hA5); push_byte(8'hA5);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                tick_q();
                n_en++;
                exp_v = (n_en % 4 == 0);
            end else begin
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                exp_v = 1'b0;
            end
            if (exp_v) exp_d = 8'hA5;
            checks++; if (DVALID !== exp_v) begin errors++; $display("FAIL gaps_dvalid cyc=%0d got=%b exp=%b", i, DVALID, exp_v); end
            checks++; if (DOUT !== exp_d)   begin errors++; $display("FAIL gaps_dout cyc=%0d got=%h exp=%h", i, DOUT, exp_d); end
        end
    endtask

    // Five filler bits put the pattern boundary three bits before the word
    // boundary, so the window must reach three bits deeper: SLIP_CNT=3.
    task automatic test_train_lock();
        logic [3:0] slip_tbl [10] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
        logic [7:0] exp_d;
        do_reset();
        TRAIN_EN = 1'b1;
        repeat (5) bq.push_back(1'b0);
        repeat (11) push_byte(8'hA5);
        repeat (19) bq.push_back(1'b0);
        for (int i = 0; i < 56; i++) begin
            tick_q();
            checks++; if (TRAIN_ERR !== 1'b0)   begin errors++; $display("FAIL lock_err cyc=%0d got=%b exp=0", i, TRAIN_ERR); end
            checks++; if (LOCKED !== (i >= 39)) begin errors++; $display("FAIL lock_locked cyc=%0d got=%b exp=%b", i, LOCKED, (i >= 39)); end
            if (i <= 39) begin
                checks++; if (DVALID !== 1'b0) begin errors++; $display("FAIL lock_train_dvalid cyc=%0d got=%b exp=0", i, DVALID); end
                if (i % 4 == 3) begin
                    checks++; if (SLIP_CNT !== slip_tbl[i/4]) begin errors++; $display("FAIL lock_slip word=%0d got=%0d exp=%0d", i/4, SLIP_CNT, slip_tbl[i/4]); end
                end
            end else begin
                checks++; if (DVALID !== (i % 4 == 3)) begin errors++; $display("FAIL lock_pass_dvalid cyc=%0d got=%b exp=%b", i, DVALID, (i % 4 == 3)); end
                if (i % 4 == 3) begin
                    exp_d = (i < 48) ? 8'hA5 : 8'h00;
                    checks++; if (DOUT !== exp_d) begin errors++; $display("FAIL lock_pass_dout cyc=%0d got=%h exp=%h", i, DOUT, exp_d); end
                end
            end
        end
        checks++; if (SLIP_CNT !== 4'd3) begin errors++; $display("FAIL lock_final_slip got=%0d exp=3", SLIP_CNT); end
    endtask

    task automatic test_train_fail();
        int         w;
        logic [3:0] exp_s;
        do_reset();
        TRAIN_EN = 1'b1;
        for (int i = 0; i < 68; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++; if (DVALID !== 1'b0)      begin errors++; $display("FAIL fail_dvalid cyc=%0d got=%b exp=0", i, DVALID); end
            checks++; if (LOCKED !== 1'b0)      begin errors++; $display("FAIL fail_locked cyc=%0d got=%b exp=0", i, LOCKED); end
            checks++; if (TRAIN_ERR !== (i >= 59)) begin errors++; $display("FAIL fail_err cyc=%0d got=%b exp=%b", i, TRAIN_ERR, (i >= 59)); end
            if (i % 4 == 3) begin
                w = i / 4;
                exp_s = (w / 2 + 1 > 7) ? 4'd7 : 4'(w / 2 + 1);
                checks++; if (SLIP_CNT !== exp_s) begin errors++; $display("FAIL fail_slip word=%0d got=%0d exp=%0d", w, SLIP_CNT, exp_s); end
            end
        end
        // Release training; data resumes through the stuck offset of 7.
        TRAIN_EN = 1'b0;
        push_byte(8'hA5); push_byte(8'hA5);
        for (int i = 68; i < 76; i++) begin
            tick_q();
            checks++; if (DVALID !== (i % 4 == 3)) begin errors++; $display("FAIL fail_resume_dvalid cyc=%0d got=%b exp=%b", i, DVALID, (i % 4 == 3)); end
            checks++; if (TRAIN_ERR !== 1'b1) begin errors++; $display("FAIL fail_resume_err cyc=%0d got=%b exp=1", i, TRAIN_ERR); end
        end
        checks++; if (DOUT !== 8'h4B)    begin errors++; $display("FAIL fail_resume_dout got=%h exp=4b", DOUT); end
        checks++; if (SLIP_CNT !== 4'd7) begin errors++; $display("FAIL fail_resume_slip got=%0d exp=7", SLIP_CNT); end
    endtask

    task automatic test_reset_mid_train();
        do_reset();
        TRAIN_EN = 1'b1;
        repeat (5) bq.push_back(1'b0);
        repeat (8) push_byte(8'hA5);
        repeat (32) tick_q();
        checks++; if (SLIP_CNT !== 4'd3) begin errors++; $display("FAIL midrst_pre_slip got=%0d exp=3", SLIP_CNT); end
        checks++; if (LOCKED !== 1'b0)   begin errors++; $display("FAIL midrst_pre_locked got=%b exp=0", LOCKED); end
        RSTB = 1'b1; TRAIN_EN = 1'b0;
        tick(1'b1, 1'b1, 1'b1);
        RSTB = 1'b0;
        checks++; if (SLIP_CNT !== 4'd0) begin errors++; $display("FAIL midrst_slip got=%0d exp=0", SLIP_CNT); end
        checks++; if (LOCKED !== 1'b0)   begin errors++; $display("FAIL midrst_locked got=%b exp=0", LOCKED); end
        checks++; if (DVALID !== 1'b0)   begin errors++; $display("FAIL midrst_dvalid got=%b exp=0", DVALID); end
        bq.delete();
        push_byte(8'h1E);
        for (int i = 0; i < 4; i++) begin
            tick_q();
            checks++; if (DVALID !== (i == 3)) begin errors++; $display("FAIL midrst_after_dvalid cyc=%0d got=%b exp=%b", i, DVALID, (i == 3)); end
        end
        checks++; if (DOUT !== 8'h1E) begin errors++; $display("FAIL midrst_after_dout got=%h exp=1e", DOUT); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_en_gaps();
        test_train_lock();
        test_train_fail();
        test_reset_mid_train();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
